pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Instruction-sequencing controller for the Hack CPU program counter. Runs a fetch/execute state machine against instruction ROM, decodes the C-instruction jump field against the ALU flags, and drives the counter's reset/load/increment controls. Sits between the ROM port, the ALU/A-register datapath and the `pc` counter. Optionally detects the Hack end-of-program self-loop and halts.

## Interface

Parameters:
- `WIDTH`, 16: address and instruction width.

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `run`  in  1  execution enable
- `rom_req`  out  1  instruction fetch request
- `rom_ack`  in  1  ROM has `instr` valid this cycle
- `instr`  in  WIDTH  instruction word from ROM
- `a_reg`  in  WIDTH  current A register (jump target)
- `zr`  in  1  ALU result == 0
- `ng`  in  1  ALU result < 0
- `exec_en`  out  1  one-cycle commit strobe for A/D/M writes
- `instr_q`  out  WIDTH  latched instruction being executed
- `pc_out`  in  WIDTH  current counter value
- `pc_reset`  out  1  to counter `reset`
- `pc_load`  out  1  to counter `load`
- `pc_incr`  out  1  to counter `incr`
- `pc_in`  out  WIDTH  to counter `in`
- `halted`  out  1  CPU stopped

## Operation

- States: IDLE, FETCH, EXEC, HALT.
- IDLE: all strobes 0. `run`=1 → FETCH.
- FETCH: `rom_req`=1. On `rom_ack`=1, latch `instr` into `instr_q`, → EXEC. Otherwise hold; `rom_req` is never withdrawn before ack, even if `run` drops.
- EXEC: `exec_en`=1 for exactly one cycle. A-instruction (`instr_q[15]`=0) → `pc_incr`=1. C-instruction: jump bits j1=`instr_q[2]` (<0), j2=`instr_q[1]` (=0), j3=`instr_q[0]` (>0); take = (j1&ng)|(j2&zr)|(j3&~zr&~ng). Taken → `pc_load`=1, `pc_in`=`a_reg`; not taken → `pc_incr`=1. `pc_load` and `pc_incr` are never both 1. Next: HALT if halt condition, else FETCH if `run`, else IDLE.
- `a_reg`, `zr`, `ng` are sampled in the EXEC cycle (pre-commit values).
- HALT: `halted`=1, all other strobes 0; exits only on `reset`.
- `pc_in` = `a_reg` when not loading (value don't-care to counter).

## Timing

- Reset: `pc_reset`=`reset` combinationally; `pc_load`/`pc_incr`/`exec_en` forced 0 during the reset cycle. After the edge: state IDLE, `rom_req`=0, `exec_en`=0, `halted`=0, `instr_q`=0, counter 0.
- Reset in any state, including mid-FETCH with `rom_req` high, aborts immediately; no `exec_en` issued for the aborted instruction.
- Minimum instruction period 2 cycles (FETCH acked same cycle, EXEC). Each ack-wait cycle adds one.
- `pc_out` reflects the new address the cycle after EXEC.
- Address arithmetic modulo 2^WIDTH; counter wrap 0xFFFF→0 is legal.

## Configuration

- `PC_CTRL_HALT_DETECT_EN` defined: in EXEC, halt condition = C-instruction with j=3'b111 AND `a_reg` == `pc_out`−1 (mod 2^WIDTH), i.e. `@N` at N, `0;JMP` at N+1. The jump is still loaded; controller then enters HALT.
- Undefined: no HALT state, `halted` tied 0, self-loop executes indefinitely.

## Structure

- Shared package `hack_pkg`: state encoding, instruction-type bit index (15), jump-field bit positions, `WIDTH` default.
- One sub-module: `jump_cond` (combinational jump-field × flags → take).

## Test plan

- Reset, `run`=1, `rom_ack`=1, `instr`=16'h0000 ×3 → `pc_incr` once per EXEC, `pc_out` 0→1→2→3 on a 2-cycle cadence.
- `instr`=16'hEA87 (0;JMP), `a_reg`=16'h0010 → `pc_load`=1, `pc_in`=16'h0010, next `pc_out`=16'h0010.
- `instr`=16'hE301 (JGT): ng=1,zr=0 → incr; ng=0,zr=0 → load `a_reg`; zr=1 → incr.
- `rom_ack`=0 for 5 cycles with `run` dropped → `rom_req` stays 1, no `exec_en`, `pc_out` constant; ack → `exec_en` next cycle.
- `pc_out`=16'h0005, 0;JMP, `a_reg`=16'h0004 → with macro `halted`=1, `rom_req`=0, `pc_out` stays 4 until reset; without macro fetching continues at 4.
- `reset` asserted during FETCH → next cycle `pc_out`=0, `rom_req`=0, state IDLE, no `exec_en`.

Source files
------------

// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the Hack CPU sequencing logic.
//   - state_e        : pc_ctrl fetch/execute state encoding
//   - INSTR_TYPE_BIT : instruction bit that selects C (1) or A (0) instruction
//   - J1/J2/J3_BIT   : jump-field bit positions (<0, =0, >0)
//   - WIDTH_DEF      : default address/instruction width
package hack_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int INSTR_TYPE_BIT = 15;
    localparam int J1_BIT         = 2;   // jump if result < 0
    localparam int J2_BIT         = 1;   // jump if result == 0
    localparam int J3_BIT         = 0;   // jump if result > 0

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/jump_cond.sv
// jump_cond: combinational Hack jump-field decode.
// Ports:
//   jump  in  3  C-instruction jump bits {j1, j2, j3}
//   zr    in  1  ALU result == 0
//   ng    in  1  ALU result < 0
//   take  out 1  jump condition satisfied
import hack_pkg::*;

module jump_cond (
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    // ~zr & ~ng is the "strictly positive" case.
    assign take = (jump[J1_BIT] & ng)
                | (jump[J2_BIT] & zr)
                | (jump[J3_BIT] & ~zr & ~ng);

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/execute sequencer driving the Hack program counter.
// Optional feature macro: PC_CTRL_HALT_DETECT_EN (end-of-program self-loop
// detection; when undefined the controller never halts and halted is 0).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   run                  execution enable
//   rom_req / rom_ack    instruction fetch handshake, instr = ROM data
//   a_reg, zr, ng        datapath jump target and ALU flags (sampled in EXEC)
//   exec_en              one-cycle commit strobe for A/D/M writes
//   instr_q              instruction currently being executed
//   pc_out               current counter value
//   pc_reset/load/incr   counter controls, pc_in = counter load value
//   halted               CPU stopped on self-loop
import hack_pkg::*;

module pc_ctrl #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             rom_req,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] a_reg,
    input  logic             zr,
    input  logic             ng,
    output logic             exec_en,
    output logic [WIDTH-1:0] instr_q,
    input  logic [WIDTH-1:0] pc_out,
    output logic             pc_reset,
    output logic             pc_load,
    output logic             pc_incr,
    output logic [WIDTH-1:0] pc_in,
    output logic             halted
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] instr_d;
    logic             rom_req_q, rom_req_d;
    logic             exec_en_q, exec_en_d;
    logic             halted_q, halted_d;
    logic             is_c;
    logic             take;
    logic             halt_hit;

    assign is_c = instr_q[INSTR_TYPE_BIT];

    jump_cond u_jump_cond (
        .jump (instr_q[J1_BIT:J3_BIT]),
        .zr   (zr),
        .ng   (ng),
        .take (take)
    );

`ifdef PC_CTRL_HALT_DETECT_EN
    // Hack end-of-program idiom: "@N" at N, "0;JMP" at N+1, so the
    // unconditional jump targets the address just before the current one.
    assign halt_hit = is_c && (instr_q[J1_BIT:J3_BIT] == 3'b111)
                   && (a_reg == pc_out - WIDTH'(1));
`else
    logic pc_out_unused;
    assign pc_out_unused = ^pc_out;
    assign halt_hit      = 1'b0;
`endif

    // Counter value only matters when loading, so a_reg can feed it directly.
    assign pc_in    = a_reg;
    assign pc_reset = reset;
    assign rom_req  = rom_req_q;
    assign halted   = halted_q;
    // Reset must suppress the commit strobe in the same cycle it is asserted.
    assign exec_en  = exec_en_q & ~reset;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        instr_d = instr_q;
        pc_load = 1'b0;
        pc_incr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Request is held until acked regardless of run.
                if (rom_ack) begin
                    instr_d = instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_c && take) pc_load = 1'b1;
                else              pc_incr = 1'b1;

                if (halt_hit) state_d = ST_HALT;
                else if (run) state_d = ST_FETCH;
                else          state_d = ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            pc_load = 1'b0;
            pc_incr = 1'b0;
        end

        rom_req_d = (state_d == ST_FETCH);
        exec_en_d = (state_d == ST_EXEC);
        halted_d  = (state_d == ST_HALT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            rom_req_q <= 1'b0;
            exec_en_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rom_req_q <= rom_req_d;
            exec_en_q <= exec_en_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl with a behavioural
// model of the Hack program counter closing the loop on pc_out.
module tb_pc_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         run;
    logic         rom_req;
    logic         rom_ack;
    logic [W-1:0] instr;
    logic [W-1:0] a_reg;
    logic         zr;
    logic         ng;
    logic         exec_en;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc_out;
    logic         pc_reset;
    logic         pc_load;
    logic         pc_incr;
    logic [W-1:0] pc_in;
    logic         halted;

    int checks = 0;
    int errors = 0;
    int exec_cnt = 0;
    int both_cnt = 0;

    pc_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .rom_req  (rom_req),
        .rom_ack  (rom_ack),
        .instr    (instr),
        .a_reg    (a_reg),
        .zr       (zr),
        .ng       (ng),
        .exec_en  (exec_en),
        .instr_q  (instr_q),
        .pc_out   (pc_out),
        .pc_reset (pc_reset),
        .pc_load  (pc_load),
        .pc_incr  (pc_incr),
        .pc_in    (pc_in),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Program counter model: reset > load > incr.
    always @(posedge clk) begin
        if (pc_reset)     pc_out <= '0;
        else if (pc_load) pc_out <= pc_in;
        else if (pc_incr) pc_out <= pc_out + 16'd1;
    end

    always @(posedge clk) begin
        if (exec_en === 1'b1) exec_cnt++;
        if (pc_load === 1'b1 && pc_incr === 1'b1) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; rom_ack = 1'b0; instr = '0;
        a_reg = '0; zr = 1'b0; ng = 1'b0;
        tick();
        tick();
        checks++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL reset_pc_reset: got %b want 1", pc_reset); end
        checks++; if ({exec_en, pc_load, pc_incr} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {exec_en, pc_load, pc_incr}); end
        reset = 1'b0;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req: got %b want 0", rom_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (instr_q !== 16'h0000) begin errors++; $display("FAIL reset_instr_q: got %h want 0000", instr_q); end
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out: got %h want 0000", pc_out); end
        tick();
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL idle_rom_req: got %b want 0", rom_req); end
    endtask

    // Three A-instructions: pc_out 0 -> 1 -> 2 -> 3, two cycles each.
    task automatic test_sequential();
        run = 1'b1; rom_ack = 1'b1; instr = 16'h0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL seq_fetch_req[%0d]: got %b want 1", i, rom_req); end
            checks++; if (pc_out !== 16'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_out, 16'(i)); end
            tick();
            checks++; if ({exec_en, pc_incr, pc_load} !== 3'b110) begin errors++; $display("FAIL seq_exec[%0d]: got %b want 110", i, {exec_en, pc_incr, pc_load}); end
            tick();
        end
        checks++; if (pc_out !== 16'h0003) begin errors++; $display("FAIL seq_pc_end: got %h want 0003", pc_out); end
    endtask

    task automatic test_jmp();
        instr = 16'hEA87; a_reg = 16'h0010; zr = 1'b0; ng = 1'b0;
        tick();
        checks++; if (instr_q !== 16'hEA87) begin errors++; $display("FAIL jmp_instr_q: got %h want EA87", instr_q); end
        checks++; if ({pc_load, pc_incr} !== 2'b10) begin errors++; $display("FAIL jmp_strobes: got %b want 10", {pc_load, pc_incr}); end
        checks++; if (pc_in !== 16'h0010) begin errors++; $display("FAIL jmp_pc_in: got %h want 0010", pc_in); end
        tick();
        checks++; if (pc_out !== 16'h0010) begin errors++; $display("FAIL jmp_pc_out: got %h want 0010", pc_out); end
    endtask

    // JGT against three flag combinations: {ng, zr, expect_load}.
    task automatic test_jgt();
        logic [2:0]   vec [3];
        logic [W-1:0] exp_pc;
        vec[0] = 3'b100; vec[1] = 3'b001; vec[2] = 3'b010;
        exp_pc = 16'h0010;
        instr = 16'hE301; a_reg = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            ng = vec[i][2]; zr = vec[i][1];
            tick();
            checks++; if ({pc_load, pc_incr} !== {vec[i][0], ~vec[i][0]}) begin errors++; $display("FAIL jgt_strobes[%0d]: got %b want %b", i, {pc_load, pc_incr}, {vec[i][0], ~vec[i][0]}); end
            exp_pc = vec[i][0] ? 16'h0020 : exp_pc + 16'd1;
            tick();
            checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL jgt_pc[%0d]: got %h want %h", i, pc_out, exp_pc); end
        end
        zr = 1'b0; ng = 1'b0;
    endtask

    // Stalled fetch with run dropped: request held, no commit, pc frozen.
    task automatic test_ack_wait();
        rom_ack = 1'b0; run = 1'b0; instr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({rom_req, exec_en} !== 2'b10) begin errors++; $display("FAIL wait_req_exec[%0d]: got %b want 10", i, {rom_req, exec_en}); end
            checks++; if (pc_out !== 16'h0021) begin errors++; $display("FAIL wait_pc[%0d]: got %h want 0021", i, pc_out); end
        end
        rom_ack = 1'b1;
        tick();
        checks++; if (exec_en !== 1'b1) begin errors++; $display("FAIL wait_exec_after_ack: got %b want 1", exec_en); end
        tick();
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL wait_idle_req: got %b want 0", rom_req); end
        checks++; if (pc_out !== 16'h0022) begin errors++; $display("FAIL wait_pc_after: got %h want 0022", pc_out); end
    endtask

    // Self-loop: @4 at 4, 0;JMP at 5.
    task automatic test_halt();
        run = 1'b1; rom_ack = 1'b1; instr = 16'hEA87; a_reg = 16'h0004;
        tick();
        tick();
        tick();
        checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL halt_setup_pc4: got %h want 0004", pc_out); end
        instr = 16'h0004;
        tick();
        tick();
        checks++; if (pc_out !== 16'h0005) begin errors++; $display("FAIL halt_setup_pc5: got %h want 0005", pc_out); end
        instr = 16'hEA87;
        tick();
        checks++; if ({pc_load, pc_in} !== {1'b1, 16'h0004}) begin errors++; $display("FAIL halt_jmp: got load=%b in=%h want load=1 in=0004", pc_load, pc_in); end
        tick();
`ifdef PC_CTRL_HALT_DETECT_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if ({halted, rom_req, exec_en} !== 3'b100) begin errors++; $display("FAIL halt_state[%0d]: got %b want 100", i, {halted, rom_req, exec_en}); end
            checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL halt_pc[%0d]: got %h want 0004", i, pc_out); end
            tick();
        end
`else
        checks++; if ({halted, rom_req} !== 2'b01) begin errors++; $display("FAIL nohalt_state: got %b want 01", {halted, rom_req}); end
        checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL nohalt_pc: got %h want 0004", pc_out); end
`endif
        reset = 1'b1; run = 1'b0;
        tick();
        reset = 1'b0;
        checks++; if ({halted, rom_req, pc_out} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL halt_exit: got halted=%b req=%b pc=%h want 0 0 0000", halted, rom_req, pc_out); end
    endtask

    task automatic test_reset_mid_fetch();
        run = 1'b1; rom_ack = 1'b1; instr = 16'h1234;
        tick();
        tick();
        tick();
        checks++; if ({pc_out, instr_q} !== {16'h0001, 16'h1234}) begin errors++; $display("FAIL rmf_setup: got pc=%h iq=%h want 0001 1234", pc_out, instr_q); end
        rom_ack = 1'b0;
        tick();
        checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL rmf_req_high: got %b want 1", rom_req); end
        reset = 1'b1; rom_ack = 1'b1;
        #1;
        checks++; if ({pc_reset, exec_en, pc_load, pc_incr} !== 4'b1000) begin errors++; $display("FAIL rmf_reset_cycle: got %b want 1000", {pc_reset, exec_en, pc_load, pc_incr}); end
        tick();
        reset = 1'b0; run = 1'b0;
        checks++; if ({pc_out, instr_q} !== {16'h0000, 16'h0000}) begin errors++; $display("FAIL rmf_cleared: got pc=%h iq=%h want 0000 0000", pc_out, instr_q); end
        checks++; if ({rom_req, exec_en} !== 2'b00) begin errors++; $display("FAIL rmf_strobes: got %b want 00", {rom_req, exec_en}); end
        tick();
        checks++; if ({rom_req, exec_en} !== 2'b00) begin errors++; $display("FAIL rmf_idle: got %b want 00", {rom_req, exec_en}); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jmp();
        test_jgt();
        test_ack_wait();
        test_halt();
        test_reset_mid_fetch();
        checks++; if (exec_cnt !== 12) begin errors++; $display("FAIL exec_count: got %0d want 12", exec_cnt); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL load_and_incr: got %0d want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
